// File: rtl/fly_hit_scorer.sv
// rtl/fly_hit_scorer.sv - turns fly hit pulses into BCD score, hit count, hit SFX and stage clear
module fly_hit_scorer #(
    parameter int          FLY_COUNT  = 12,
    parameter logic [15:0] POINTS_BCD = 16'h0010,
    parameter int          SFX_LEN    = 1250000,
    parameter int          HALF_A     = 14205,
    parameter int          HALF_B     = 9479
) (
    input  logic                 clk25,
    input  logic                 reset_n,
    input  logic [FLY_COUNT-1:0] fly_hit,
    input  logic [FLY_COUNT-1:0] fly_alive,
    input  logic                 score_clr,
    output logic [15:0]          score_bcd,
    output logic [7:0]           hit_count,
    output logic                 sfx_buzz,
    output logic                 sfx_active,
    output logic                 stage_clear
);

    localparam int PW     = $clog2(FLY_COUNT + 1);
    localparam int SUMW   = ((PW > 5) ? PW : 5) + 1;
    localparam int HMAX   = (HALF_A > HALF_B) ? HALF_A : HALF_B;
    localparam int HALF_W = $clog2(HMAX + 1);
    localparam int SEG_W  = $clog2(SFX_LEN + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_TONE_A = 2'd1;
    localparam logic [1:0] ST_TONE_B = 2'd2;

    logic [4:0]        pending_q, pending_d;
    logic [15:0]       score_q, score_d;
    logic [7:0]        hit_count_q, hit_count_d;
    logic [1:0]        state_q, state_d;
    logic [SEG_W-1:0]  seg_cnt_q, seg_cnt_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [HALF_W-1:0] half_lim;
    logic              buzz_q, buzz_d;
    logic              active_q, active_d;
    logic              armed_q, armed_d;
    logic              clear_q, clear_d;
    logic [PW-1:0]     pop, pop_eff;
    logic [SUMW-1:0]   pending_sum;
    logic [16:0]       bcd_sum;

    // Bit 16 of the result is the carry out of digit 3, used for saturation.
    function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
        logic [4:0]  d;
        logic        c;
        logic [15:0] r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            if (d > 5'd9) begin
                d = d - 5'd10;
                c = 1'b1;
            end else begin
                c = 1'b0;
            end
            r[4*i +: 4] = d[3:0];
        end
        return {c, r};
    endfunction

    always_comb begin
        pop = '0;
        for (int i = 0; i < FLY_COUNT; i++) begin
            pop = pop + PW'(fly_hit[i]);
        end
        pop_eff = score_clr ? '0 : pop;
    end

    always_comb begin
        pending_sum = SUMW'(pending_q) + SUMW'(pop_eff) - SUMW'(pending_q != 5'd0);
        bcd_sum     = bcd_add(score_q, POINTS_BCD);
        pending_d   = (pending_sum > SUMW'(31)) ? 5'd31 : pending_sum[4:0];
        score_d     = score_q;
        hit_count_d = hit_count_q;
        if (score_clr) begin
            pending_d   = 5'd0;
            score_d     = 16'h0000;
            hit_count_d = 8'd0;
        end else if (pending_q != 5'd0) begin
            score_d     = bcd_sum[16] ? 16'h9999 : bcd_sum[15:0];
            hit_count_d = (hit_count_q == 8'hFF) ? 8'hFF : hit_count_q + 8'd1;
        end
    end

    // A new hit always restarts the two-tone sequence from the first tone.
    always_comb begin
        state_d    = state_q;
        seg_cnt_d  = seg_cnt_q;
        half_cnt_d = half_cnt_q;
        buzz_d     = buzz_q;
        half_lim   = (state_q == ST_TONE_A) ? HALF_W'(HALF_A - 1) : HALF_W'(HALF_B - 1);
        if (pop_eff != '0) begin
            state_d    = ST_TONE_A;
            seg_cnt_d  = '0;
            half_cnt_d = '0;
            buzz_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    buzz_d = 1'b0;
                end
                ST_TONE_A, ST_TONE_B: begin
                    if (seg_cnt_q == SEG_W'(SFX_LEN - 1)) begin
                        state_d    = (state_q == ST_TONE_A) ? ST_TONE_B : ST_IDLE;
                        seg_cnt_d  = '0;
                        half_cnt_d = '0;
                        buzz_d     = 1'b0;
                    end else begin
                        seg_cnt_d = seg_cnt_q + SEG_W'(1);
                        if (half_cnt_q == half_lim) begin
                            half_cnt_d = '0;
                            buzz_d     = ~buzz_q;
                        end else begin
                            half_cnt_d = half_cnt_q + HALF_W'(1);
                        end
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    seg_cnt_d  = '0;
                    half_cnt_d = '0;
                    buzz_d     = 1'b0;
                end
            endcase
        end
        active_d = (state_d != ST_IDLE);
    end

    // armed simply follows "any fly alive", so a dead mask both fires and disarms.
    always_comb begin
        armed_d = |fly_alive;
        clear_d = armed_q && !(|fly_alive);
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            pending_q   <= 5'd0;
            score_q     <= 16'h0000;
            hit_count_q <= 8'd0;
            state_q     <= ST_IDLE;
            seg_cnt_q   <= '0;
            half_cnt_q  <= '0;
            buzz_q      <= 1'b0;
            active_q    <= 1'b0;
            armed_q     <= 1'b0;
            clear_q     <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            score_q     <= score_d;
            hit_count_q <= hit_count_d;
            state_q     <= state_d;
            seg_cnt_q   <= seg_cnt_d;
            half_cnt_q  <= half_cnt_d;
            buzz_q      <= buzz_d;
            active_q    <= active_d;
            armed_q     <= armed_d;
            clear_q     <= clear_d;
        end
    end

    assign score_bcd   = score_q;
    assign hit_count   = hit_count_q;
    assign sfx_buzz    = buzz_q;
    assign sfx_active  = active_q;
    assign stage_clear = clear_q;

endmodule

// File: tb/tb_fly_hit_scorer.sv
// tb/tb_fly_hit_scorer.sv - directed self-checking bench for fly_hit_scorer
module tb_fly_hit_scorer;

    logic        clk25;
    logic        reset_n;
    logic [11:0] fly_hit;
    logic [11:0] fly_alive;
    logic        score_clr;
    logic [15:0] score_bcd;
    logic [7:0]  hit_count;
    logic        sfx_buzz;
    logic        sfx_active;
    logic        stage_clear;

    int checks = 0;
    int errors = 0;

    fly_hit_scorer #(
        .FLY_COUNT (12),
        .POINTS_BCD(16'h0010),
        .SFX_LEN   (20),
        .HALF_A    (3),
        .HALF_B    (2)
    ) dut (
        .clk25      (clk25),
        .reset_n    (reset_n),
        .fly_hit    (fly_hit),
        .fly_alive  (fly_alive),
        .score_clr  (score_clr),
        .score_bcd  (score_bcd),
        .hit_count  (hit_count),
        .sfx_buzz   (sfx_buzz),
        .sfx_active (sfx_active),
        .stage_clear(stage_clear)
    );

    initial clk25 = 1'b0;
    always #5 clk25 = ~clk25;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    // Logs sfx_buzz per cycle from index n0 until the tone sequence ends.
    task automatic sfx_capture(input int n0, output int n, output logic [63:0] lg);
        n  = n0;
        lg = '0;
        while (sfx_active && n < 100) begin
            if (n < 64) lg[n] = sfx_buzz;
            n++;
            step();
        end
    endtask

    // Tone A toggles every 3 cycles for 20 cycles, tone B every 2 cycles for 20 cycles.
    function automatic logic [63:0] exp_buzz();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 20; k++) v[k] = ((k / 3) % 2) == 1;
        for (int j = 0; j < 20; j++) v[20 + j] = ((j / 2) % 2) == 1;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          n;
        int          pulses;
        logic [63:0] lg;
        logic        b0, b1;

        reset_n   = 1'b0;
        fly_hit   = '0;
        fly_alive = '0;
        score_clr = 1'b0;
        step();
        step();
        check("rst_score", score_bcd, 16'h0000);
        check("rst_hits", hit_count, 8'd0);
        check("rst_sfx", {sfx_buzz, sfx_active}, 2'b00);
        check("rst_clear", stage_clear, 1'b0);
        reset_n = 1'b1;
        step();

        // single hit: latency and tone length/shape
        fly_hit = 12'h001;
        step();
        fly_hit = '0;
        b0 = sfx_buzz;
        check("lat_edge1_score", score_bcd, 16'h0000);
        check("lat_edge1_active", sfx_active, 1'b1);
        step();
        b1 = sfx_buzz;
        check("lat_edge2_score", score_bcd, 16'h0010);
        check("lat_edge2_hits", hit_count, 8'd1);
        step();
        sfx_capture(2, n, lg);
        lg[0] = b0;
        lg[1] = b1;
        check("sfx_len", n, 40);
        check("sfx_wave", lg, exp_buzz());
        check("sfx_idle_buzz", sfx_buzz, 1'b0);

        // clear wins over a same-cycle hit
        score_clr = 1'b1;
        fly_hit   = 12'hFFF;
        step();
        score_clr = 1'b0;
        fly_hit   = '0;
        step();
        step();
        check("clr_score", score_bcd, 16'h0000);
        check("clr_hits", hit_count, 8'd0);

        // twelve simultaneous hits drain one per cycle
        fly_hit = 12'hFFF;
        step();
        fly_hit = '0;
        repeat (6) step();
        check("burst_mid", score_bcd, 16'h0060);
        repeat (6) step();
        check("burst_end", score_bcd, 16'h0120);
        check("burst_hits", hit_count, 8'd12);
        repeat (3) step();
        check("burst_hold", score_bcd, 16'h0120);

        // saturation of score and hit counter
        score_clr = 1'b1;
        step();
        score_clr = 1'b0;
        fly_hit   = 12'h001;
        repeat (999) step();
        fly_hit = '0;
        step();
        check("sat_9990", score_bcd, 16'h9990);
        check("sat_hits", hit_count, 8'd255);
        fly_hit = 12'h003;
        step();
        fly_hit = '0;
        repeat (3) step();
        check("sat_9999", score_bcd, 16'h9999);
        repeat (3) step();
        check("sat_hold", score_bcd, 16'h9999);
        check("sat_hits_hold", hit_count, 8'd255);

        // restart from tone B cycle 5
        repeat (60) step();
        check("idle_before_restart", sfx_active, 1'b0);
        fly_hit = 12'h010;
        step();
        fly_hit = '0;
        repeat (25) step();
        check("in_tone_b", sfx_active, 1'b1);
        fly_hit = 12'h100;
        step();
        fly_hit = '0;
        check("restart_buzz", sfx_buzz, 1'b0);
        sfx_capture(0, n, lg);
        check("restart_len", n, 40);
        check("restart_wave", lg, exp_buzz());

        // stage clear
        pulses = 0;
        repeat (5) begin
            step();
            if (stage_clear) pulses++;
        end
        check("no_pulse_unarmed", pulses, 0);
        fly_alive = 12'h003;
        step();
        step();
        fly_alive = 12'h001;
        step();
        step();
        check("no_pulse_alive", stage_clear, 1'b0);
        fly_alive = 12'h000;
        step();
        check("clear_pulse", stage_clear, 1'b1);
        pulses = 0;
        repeat (5) begin
            step();
            if (stage_clear) pulses++;
        end
        check("clear_once", pulses, 0);

        // async reset while tone A is running with hits pending
        fly_hit = 12'h07F;
        step();
        fly_hit = 12'h001;
        step();
        step();
        fly_hit = '0;
        check("pre_reset_score", score_bcd, 16'h9999);
        score_clr = 1'b1;
        step();
        score_clr = 1'b0;
        fly_hit   = 12'h07F;
        step();
        fly_hit = 12'h001;
        step();
        step();
        fly_hit = '0;
        check("pre_reset_score2", score_bcd, 16'h0020);
        check("pre_reset_active", sfx_active, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_reset_out", {score_bcd, hit_count, sfx_buzz, sfx_active, stage_clear}, 27'd0);
        #1;
        reset_n = 1'b1;
        repeat (10) step();
        check("post_reset_score", score_bcd, 16'h0000);
        check("post_reset_hits", hit_count, 8'd0);
        check("post_reset_active", sfx_active, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
